// File: rtl/mem.sv
// 32 x 4-bit data RAM for the TI4 CPU: writes on the rising clk edge, combinational read of mem[addr].
// Latency: a write is visible on data_out right after its edge; there is no backpressure (one write per cycle, read port always valid).
module mem #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] words [DEPTH];

  // Reset clears the whole array at once, so data_out reads 0 everywhere while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else if (we) begin
      words[addr] <= data_in;
    end
  end

  assign data_out = words[addr];

endmodule

// File: tb/tb_mem.sv
// Directed plus randomized bench for mem, checked against an array reference model.
module tb_mem;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [4:0] addr;
  logic [3:0] data_in;
  logic [3:0] data_out;

  logic [3:0] model [32];
  int n_assert;
  int n_fail;

  mem #(.DATA_W(4), .ADDR_W(5), .DEPTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    n_assert++;
    assert (data_out === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, data_out, exp);
      end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 4'd0;
  endtask

  // Write is set up at the falling edge and committed at the next rising edge.
  task automatic do_write(input logic [4:0] a, input logic [3:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    data_in = d;
    @(posedge clk);
    #1;
    if (rst_n) model[a] = d;
    we = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input string tag);
    @(negedge clk);
    addr = a;
    #1;
    check(tag, model[a]);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    we = 1'b0;
    addr = '0;
    data_in = '0;
    model_clear();

    // Reset clear
    repeat (2) @(posedge clk);
    #1;
    addr = 5'd0;  #1; check("reset_addr0", 4'd0);
    addr = 5'd1;  #1; check("reset_addr1", 4'd0);
    addr = 5'd31; #1; check("reset_addr31", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential write/read
    do_write(5'd0, 4'd1);
    do_write(5'd1, 4'd2);
    do_write(5'd2, 4'd3);
    do_read(5'd0, "seq_read0");
    do_read(5'd1, "seq_read1");
    do_read(5'd2, "seq_read2");
    n_assert++;
    assert (model[1] === 4'd2)
      else begin
        n_fail++;
        $error("FAIL model_seq1: observed %0h expected %0h", model[1], 4'd2);
      end

    // Write disable
    @(negedge clk);
    we = 1'b0;
    addr = 5'd1;
    data_in = 4'd15;
    repeat (4) @(posedge clk);
    #1;
    check("we0_hold_addr1", 4'd2);

    // Boundary and overwrite
    do_write(5'd31, 4'd15);
    do_read(5'd31, "bound_write15");
    do_write(5'd31, 4'd5);
    do_read(5'd31, "bound_overwrite5");
    do_read(5'd30, "bound_neighbour30");

    // Combinational read: addr changes between edges
    @(negedge clk);
    addr = 5'd2; #1; check("comb_addr2", 4'd3);
    addr = 5'd0; #1; check("comb_addr0", 4'd1);
    addr = 5'd31; #1; check("comb_addr31", 4'd5);

    // Same-address read-during-write
    @(negedge clk);
    we = 1'b1;
    addr = 5'd1;
    data_in = 4'd10;
    #1;
    check("rdw_before_edge", 4'd2);
    @(posedge clk);
    #1;
    model[1] = 4'd10;
    we = 1'b0;
    check("rdw_after_edge", 4'd10);

    // Async reset mid-run
    do_write(5'd4, 4'd9);
    @(negedge clk);
    addr = 5'd4;
    #1;
    check("pre_reset_addr4", 4'd9);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("async_reset_addr4", 4'd0);
    // Writes attempted while held in reset are ignored
    we = 1'b1;
    data_in = 4'd7;
    @(posedge clk);
    #1;
    check("write_in_reset", 4'd0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(5'd4, "post_release_addr4");
    do_read(5'd1, "post_release_addr1");

    // A write at the first edge after release is performed
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1;
    addr = 5'd7;
    data_in = 4'd6;
    @(posedge clk);
    #1;
    model[7] = 4'd6;
    we = 1'b0;
    check("first_edge_write", 4'd6);

    // Randomized writes and reads against the model
    for (int i = 0; i < 300; i++) begin
      logic [4:0] ra;
      logic [3:0] rd;
      ra = 5'($urandom_range(0, 31));
      rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(ra, rd);
        check("rand_write_visible", model[ra]);
      end else begin
        do_read(ra, "rand_read");
      end
    end

    // Final sweep of every address
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), "final_sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
